// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the RV32I core's single memory port between fetch and load/store.
// Optional misaligned-access trap is compiled in when MISALIGN_TRAP_EN is defined.
module mem_port_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [2:0]      d_funct3,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_valid,
    output logic            d_err,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready
);

    localparam int STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    store_be = 4'b0001 << off;
            F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        case (f3)
            F3_B:    store_lanes = {(XLEN/8){wd[7:0]}};
            F3_H:    store_lanes = {(XLEN/16){wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend; unknown funct3 behaves as LW.
    function automatic logic [XLEN-1:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] rd);
        logic [XLEN-1:0] sh;
        case (f3)
            F3_B, F3_BU: sh = rd >> {off, 3'b000};
            F3_H, F3_HU: sh = rd >> {off[1], 4'b0000};
            default:     sh = rd;
        endcase
        case (f3)
            F3_B:    load_format = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_BU:   load_format = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_H:    load_format = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_HU:   load_format = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: load_format = sh;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: is_misaligned = off[0];
            F3_W:        is_misaligned = (off != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_t            state_r, state_s;
    logic [STREAK_W-1:0] streak_r, streak_s;
    logic [2:0]        d_f3_r, d_f3_s;
    logic [1:0]        d_off_r, d_off_s;
    logic              mem_req_r, mem_req_s;
    logic              mem_we_r, mem_we_s;
    logic [3:0]        mem_be_r, mem_be_s;
    logic [XLEN-1:0]   mem_addr_r, mem_addr_s;
    logic [XLEN-1:0]   mem_wdata_r, mem_wdata_s;
    logic [XLEN-1:0]   if_rdata_r, if_rdata_s;
    logic              if_valid_r, if_valid_s;
    logic [XLEN-1:0]   d_rdata_r, d_rdata_s;
    logic              d_valid_r, d_valid_s;
    logic              d_err_r, d_err_s;
    logic              grant_d_s, grant_if_s;
    logic              trap_s;
    logic              unused_addr_bits_s;

`ifdef MISALIGN_TRAP_EN
    assign trap_s = is_misaligned(d_funct3, d_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    // Fetch is always word aligned; the low address bits carry no information.
    assign unused_addr_bits_s = &{1'b0, if_addr[1:0]};

    // Next-state, arbitration and registered-output next values.
    always_comb begin
        state_s     = state_r;
        streak_s    = streak_r;
        d_f3_s      = d_f3_r;
        d_off_s     = d_off_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_be_s    = mem_be_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        if_valid_s  = 1'b0;
        d_rdata_s   = d_rdata_r;
        d_valid_s   = 1'b0;
        d_err_s     = 1'b0;
        grant_d_s   = 1'b0;
        grant_if_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (d_req && if_req) begin
                    if ((MAX_DATA_STREAK == 0) || (streak_r < STREAK_MAX)) begin
                        grant_d_s = 1'b1;
                        streak_s  = (streak_r < STREAK_MAX) ? streak_r + STREAK_ONE : streak_r;
                    end else begin
                        grant_if_s = 1'b1;
                        streak_s   = '0;
                    end
                end else if (d_req) begin
                    grant_d_s = 1'b1;
                    streak_s  = '0;
                end else if (if_req) begin
                    grant_if_s = 1'b1;
                    streak_s   = '0;
                end else begin
                    streak_s = streak_r;
                end

                if (grant_d_s && trap_s) begin
                    // Trapped access never reaches memory; it completes at this edge.
                    d_valid_s = 1'b1;
                    d_err_s   = 1'b1;
                    d_rdata_s = '0;
                end else if (grant_d_s) begin
                    state_s     = BUSY_D;
                    d_f3_s      = d_funct3;
                    d_off_s     = d_addr[1:0];
                    mem_req_s   = 1'b1;
                    mem_we_s    = d_we;
                    mem_be_s    = d_we ? store_be(d_funct3, d_addr[1:0]) : 4'b1111;
                    mem_addr_s  = {d_addr[XLEN-1:2], 2'b00};
                    mem_wdata_s = d_we ? store_lanes(d_funct3, d_wdata) : '0;
                end else if (grant_if_s) begin
                    state_s     = BUSY_IF;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_be_s    = 4'b1111;
                    mem_addr_s  = {if_addr[XLEN-1:2], 2'b00};
                    mem_wdata_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_rdata_s = mem_rdata;
                    if_valid_s = 1'b1;
                    mem_req_s  = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = BUSY_IF;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_rdata_s = mem_we_r ? '0 : load_format(d_f3_r, d_off_r, mem_rdata);
                    d_valid_s = 1'b1;
                    mem_req_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s = BUSY_D;
                end
            end
            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            streak_r    <= '0;
            d_f3_r      <= 3'b000;
            d_off_r     <= 2'b00;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= 4'b0000;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            if_rdata_r  <= '0;
            if_valid_r  <= 1'b0;
            d_rdata_r   <= '0;
            d_valid_r   <= 1'b0;
            d_err_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            streak_r    <= streak_s;
            d_f3_r      <= d_f3_s;
            d_off_r     <= d_off_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_be_r    <= mem_be_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            if_valid_r  <= if_valid_s;
            d_rdata_r   <= d_rdata_s;
            d_valid_r   <= d_valid_s;
            d_err_r     <= d_err_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_be    = mem_be_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign d_rdata   = d_rdata_r;
    assign d_valid   = d_valid_r;
    assign d_err     = d_err_r;
    assign stall_if  = if_req & ~if_valid_r;
    assign stall_mem = d_req & ~d_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses, a simple memory responder,
// and a monitor that checks every valid pulse against the expected-response queue.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_if;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wait_n  = 0;
    int          wcnt    = 0;
    bit          use_fixed = 1'b1;
    logic [31:0] fixed_rdata = 32'h0;

    logic        req_seen = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    mem_port_arbiter #(.XLEN(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: ready after wait_n stall cycles; data is fixed or address-derived.
    always @(posedge clk) begin
        #1;
        if (mem_req !== 1'b1) begin
            wcnt      = 0;
            mem_ready = 1'b0;
        end else begin
            mem_ready = (wcnt >= wait_n);
            wcnt++;
        end
        mem_rdata = use_fixed ? fixed_rdata : (mem_addr ^ 32'hA5A5_0000);
    end

    // Monitor: capture each memory request, pop and compare on every valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (mem_req === 1'b1 && !req_seen) begin
            cap_addr  = mem_addr;
            cap_be    = mem_be;
            cap_we    = mem_we;
            cap_wdata = mem_wdata;
            req_seen  = 1'b1;
        end else if (mem_req !== 1'b1) begin
            req_seen = 1'b0;
        end
        if (if_valid === 1'b1 || d_valid === 1'b1) begin
            if (if_valid === 1'b1 && d_valid === 1'b1) chk("dual_valid", 32'd1, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", {30'd0, if_valid, d_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant_kind", {31'd0, if_valid}, {31'd0, e.is_if});
                if (e.is_if) begin
                    chk("if_rdata", if_rdata, e.rdata);
                end else begin
                    chk("d_rdata", d_rdata, e.rdata);
                    chk("d_err", {31'd0, d_err}, {31'd0, e.err});
                end
                if (!e.err) begin
                    chk("mem_addr", cap_addr, e.addr);
                    chk("mem_be", {28'd0, cap_be}, {28'd0, e.be});
                    chk("mem_we", {31'd0, cap_we}, {31'd0, e.we});
                    if (e.we) chk("mem_wdata", cap_wdata, e.wdata);
                end
            end
        end
    end

    task automatic push(input bit is_if, input logic [31:0] rd, input bit err, input logic [31:0] addr,
                        input logic [3:0] be, input bit we, input logic [31:0] wd);
        exp_t e;
        e.is_if = is_if; e.rdata = rd; e.err = err; e.addr = addr;
        e.be = be; e.we = we; e.wdata = wd;
        sb.push_back(e);
    endtask

    task automatic data_access(input string name, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] mem_word, input logic [31:0] exp_rd,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd,
                               input logic [31:0] exp_addr, input bit exp_err,
                               input int waits, input int exp_lat);
        int lat = 0;
        bit got = 1'b0, saw_req = 1'b0, stall_ok = 1'b1;
        @(negedge clk);
        use_fixed = 1'b1; fixed_rdata = mem_word; wait_n = waits;
        push(1'b0, exp_rd, exp_err, exp_addr, exp_be, we, exp_wd);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (mem_req === 1'b1) saw_req = 1'b1;
            if (d_valid === 1'b1) begin
                got = 1'b1;
                if (stall_mem !== 1'b0) stall_ok = 1'b0;
            end else if (stall_mem !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        d_req = 1'b0;
        chk({name, "_done"}, {31'd0, got}, 32'd1);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_stall_mem"}, {31'd0, stall_ok}, 32'd1);
        if (exp_err) chk({name, "_no_mem_req"}, {31'd0, saw_req}, 32'd0);
    endtask

    task automatic fetch(input string name, input logic [31:0] addr, input int waits,
                         input logic [31:0] exp_addr, input logic [31:0] exp_rd);
        int lat = 0, req_cycles = 0;
        bit got = 1'b0, addr_ok = 1'b1, stall_ok = 1'b1;
        @(negedge clk);
        use_fixed = 1'b0; wait_n = waits;
        push(1'b1, exp_rd, 1'b0, exp_addr, 4'b1111, 1'b0, 32'h0);
        if_req = 1'b1; if_addr = addr;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (mem_addr !== exp_addr) addr_ok = 1'b0;
            end
            if (if_valid === 1'b1) got = 1'b1;
            else if (stall_if !== 1'b1) stall_ok = 1'b0;
        end
        if_req = 1'b0;
        chk({name, "_done"}, {31'd0, got}, 32'd1);
        chk({name, "_latency"}, lat, waits + 2);
        chk({name, "_req_cycles"}, req_cycles, waits + 1);
        chk({name, "_addr_stable"}, {31'd0, addr_ok}, 32'd1);
        chk({name, "_stall_if"}, {31'd0, stall_ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        bit stall_ok;
        int lat;
        bit got;
        rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_funct3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_valids", {29'd0, if_valid, d_valid, d_err}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        rst = 1'b1;

        // Load/store formatting and byte lanes
        data_access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h100, 1'b0, 0, 2);
        data_access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 32'hFFFFFF80, 4'b1111, 32'h0, 32'h100, 1'b0, 0, 2);
        data_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 32'h00000080, 4'b1111, 32'h0, 32'h100, 1'b0, 0, 2);
        data_access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 32'hFFFF80FF, 4'b1111, 32'h0, 32'h100, 1'b0, 0, 2);
        data_access("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 32'h00001234, 4'b1111, 32'h0, 32'h100, 1'b0, 0, 2);
        data_access("sh", 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 32'h0, 4'b1100, 32'h12341234, 32'h100, 1'b0, 0, 2);
        data_access("sb", 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h100, 1'b0, 0, 2);
        data_access("sw_wait", 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h200, 1'b0, 2, 4);

        // Fetch with wait states, and fetch with ignored low address bits
        fetch("fetch_wait", 32'h40, 3, 32'h40, 32'hA5A50040);
        fetch("fetch_low", 32'h47, 0, 32'h44, 32'hA5A50044);

        // Both requesters held: four data grants, then one fetch, repeated
        @(negedge clk);
        use_fixed = 1'b0; wait_n = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) push(1'b1, 32'hA5A50080, 1'b0, 32'h80, 4'b1111, 1'b0, 32'h0);
            else push(1'b0, 32'hA5A50300, 1'b0, 32'h300, 4'b1111, 1'b0, 32'h0);
        end
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h300;
        nv = 0; stall_ok = 1'b1;
        for (int i = 0; i < 200 && nv < 10; i++) begin
            @(negedge clk);
            if (if_valid === 1'b1) nv++;
            if (d_valid === 1'b1) nv++;
            if (if_valid !== 1'b1 && stall_if !== 1'b1) stall_ok = 1'b0;
            if (if_valid === 1'b1 && stall_if !== 1'b0) stall_ok = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("streak_grants", nv, 10);
        chk("streak_stall_if", {31'd0, stall_ok}, 32'd1);

        // Reset in the middle of a stalled data access aborts it
        @(negedge clk);
        use_fixed = 1'b1; fixed_rdata = 32'h11223344; wait_n = 1000;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h100;
        repeat (3) @(negedge clk);
        chk("abort_pre_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        chk("abort_no_valid", {31'd0, d_valid}, 32'd0);
        chk("abort_d_rdata", d_rdata, 32'd0);
        chk("abort_stall_mem", {31'd0, stall_mem}, 32'd1);
        wait_n = 0;
        push(1'b0, 32'h11223344, 1'b0, 32'h100, 4'b1111, 1'b0, 32'h0);
        rst = 1'b1;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (d_valid === 1'b1) got = 1'b1;
        end
        d_req = 1'b0;
        chk("regrant_done", {31'd0, got}, 32'd1);
        chk("regrant_latency", lat, 2);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        data_access("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h99887766, 32'h0, 4'b1111, 32'h0, 32'h100, 1'b1, 0, 1);
`else
        data_access("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 32'h99887766, 32'h99887766, 4'b1111, 32'h0, 32'h100, 1'b0, 0, 2);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
